// File: rtl/mac_tx_framer_pkg.sv
// Shared types and constants for the Ethernet transmit framer and its CRC engine.
package mac_tx_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int          PREAMBLE_LEN  = 7;
  localparam int          FCS_LEN       = 4;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;

  // MSB-first CRC-32 register; Ethernet sends each byte LSB first, so data bits enter from bit 0 up.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++)
      c = {c[30:0], 1'b0} ^ ((c[31] ^ d[i]) ? CRC_POLY : 32'h0);
    return c;
  endfunction

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/mac_tx_framer_crc_gen.sv
// CRC-32 accumulator: init, byte update, or byte-wise shift-out of the result.
module crc_gen
  import mac_tx_framer_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        init_i,
  input  logic        en_i,
  input  logic        rden_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init_i)      crc_d = CRC_INIT;
    else if (en_i)   crc_d = crc32_byte(crc_q, data_i);
    else if (rden_i) crc_d = {crc_q[23:0], 8'h00};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) crc_q <= CRC_INIT;
    else          crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/mac_tx_framer.sv
// Byte-wide Ethernet TX framer: preamble/SFD, payload with zero pad, FCS, inter-frame gap.
module mac_tx_framer
  import mac_tx_framer_pkg::*;
#(
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1514,
  parameter int IFG_LEN = 12
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] txd,
  output logic       tx_en,
  output logic       tx_er,
  output logic       busy,
  output logic       frame_done
);

  state_e      state_q, state_d;
  logic [10:0] cnt_q, cnt_d, cnt_nxt;
  logic [15:0] tmr_q, tmr_d;
  logic        abort;
  logic        crc_init, crc_en, crc_rden;
  logic [7:0]  crc_data;
  logic [31:0] crc;

  assign cnt_nxt = cnt_q + 11'd1;
  // Underrun or length cap both end the frame with a single error byte.
  assign abort   = (state_q == ST_DATA) && (!in_valid || cnt_q == 11'(MAX_LEN));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:     if (in_valid) state_d = ST_PREAMBLE;
      ST_PREAMBLE: if (tmr_q == 16'(PREAMBLE_LEN - 1)) state_d = ST_SFD;
      ST_SFD: begin
        cnt_d   = '0;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (abort) state_d = ST_IFG;
        else begin
          cnt_d = cnt_nxt;
          if (in_last) state_d = (cnt_nxt < 11'(MIN_LEN)) ? ST_PAD : ST_FCS;
        end
      end
      ST_PAD: begin
        cnt_d = cnt_nxt;
        if (cnt_nxt == 11'(MIN_LEN)) state_d = ST_FCS;
      end
      ST_FCS:  if (tmr_q == 16'(FCS_LEN - 1)) state_d = ST_IFG;
      ST_IFG:  if (tmr_q == 16'(IFG_LEN - 1)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Per-state cycle timer restarts on every transition.
    tmr_d = (state_d != state_q) ? 16'd0 : tmr_q + 16'd1;
  end

  always_comb begin
    in_ready   = 1'b0;
    txd        = 8'h00;
    tx_en      = 1'b0;
    tx_er      = 1'b0;
    frame_done = 1'b0;
    crc_init   = 1'b0;
    crc_en     = 1'b0;
    crc_rden   = 1'b0;
    crc_data   = 8'h00;
    busy       = (state_q != ST_IDLE);
    case (state_q)
      ST_PREAMBLE: begin
        txd   = PREAMBLE_BYTE;
        tx_en = 1'b1;
      end
      ST_SFD: begin
        txd      = SFD_BYTE;
        tx_en    = 1'b1;
        crc_init = 1'b1;
      end
      ST_DATA: begin
        in_ready = (cnt_q != 11'(MAX_LEN));
        tx_en    = 1'b1;
        if (abort) tx_er = 1'b1;
        else begin
          txd      = in_data;
          crc_en   = 1'b1;
          crc_data = in_data;
        end
      end
      ST_PAD: begin
        tx_en  = 1'b1;
        crc_en = 1'b1;
      end
      ST_FCS: begin
        txd      = bitrev8(~crc[31:24]);
        tx_en    = 1'b1;
        crc_rden = 1'b1;
      end
      ST_IFG:  frame_done = (tmr_q == 16'(IFG_LEN - 1));
      default: ;
    endcase
  end

  crc_gen u_crc_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .init_i  (crc_init),
    .en_i    (crc_en),
    .rden_i  (crc_rden),
    .data_i  (crc_data),
    .crc_o   (crc)
  );

endmodule

// File: tb/tb_mac_tx_framer.sv
// Scoreboard bench for mac_tx_framer: stimulus queues expected line bytes, monitor pops on tx_en.
module tb_mac_tx_framer;

  localparam int MIN_LEN = 60;
  localparam int MAX_LEN = 1514;
  localparam int IFG_LEN = 12;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid, in_last;
  logic [7:0] in_data;
  logic       in_ready, tx_en, tx_er, busy, frame_done;
  logic [7:0] txd;

  always #5 clk = ~clk;

  mac_tx_framer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .IFG_LEN(IFG_LEN)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .txd        (txd),
    .tx_en      (tx_en),
    .tx_er      (tx_er),
    .busy       (busy),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       er;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] pay[$];
  logic [7:0] cap_q[$];
  logic [7:0] last_cap[$];
  int n_cmp = 0, n_err = 0;
  int en_cnt = 0, last_len = 0, low_cnt = 0, idle_cnt = 0;
  int gap_low = 0, gap_idle = 0, done_gap = 0, er_cnt = 0;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  // Reference CRC-32 in the reflected form (poly 0xEDB88320).
  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  function automatic logic [12:0] outs();
    return {txd, tx_en, tx_er, in_ready, busy, frame_done};
  endfunction

  // Monitor: every tx_en cycle pops one expected byte; also tracks frame/gap timing.
  initial begin
    exp_t e;
    bit   prev_en;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_en) begin
        if (!prev_en) begin
          en_cnt = 0; gap_low = low_cnt; gap_idle = idle_cnt; cap_q.delete();
        end
        if (tx_er) er_cnt++;
        cap_q.push_back(txd);
        if (exp_q.size() == 0) chk($sformatf("unexpected tx byte %0d", en_cnt), 1, 0);
        else begin
          e = exp_q.pop_front();
          chk($sformatf("txd[%0d]", en_cnt), txd, e.d);
          chk($sformatf("tx_er[%0d]", en_cnt), tx_er, e.er);
        end
        en_cnt++;
      end else begin
        if (prev_en) begin
          last_len = en_cnt; low_cnt = 0; idle_cnt = 0; last_cap = cap_q;
        end
        low_cnt++;
        if (!busy) idle_cnt++;
        if (frame_done) done_gap = low_cnt;
      end
      prev_en = tx_en;
    end
  end

  task automatic exp_frame(input int n, input bit abrt);
    logic [31:0] c, f;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 7; i++) exp_q.push_back('{8'h55, 1'b0});
    exp_q.push_back('{8'hD5, 1'b0});
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{pay[i], 1'b0});
      c = ref_crc(c, pay[i]);
    end
    if (abrt) exp_q.push_back('{8'h00, 1'b1});
    else begin
      for (int i = n; i < MIN_LEN; i++) begin
        exp_q.push_back('{8'h00, 1'b0});
        c = ref_crc(c, 8'h00);
      end
      f = ~c;
      for (int k = 0; k < 4; k++) exp_q.push_back('{f[8*k +: 8], 1'b0});
    end
  endtask

  task automatic send(input int n, input bit with_last, input bit keep, input int tmo, output int acc);
    bit got;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_data = pay[i]; in_last = with_last && (i == n - 1);
      got = 1'b0;
      for (int w = 0; w < tmo && !got; w++) begin
        @(negedge clk); got = in_ready;
        @(posedge clk); #1;
      end
      if (!got) break;
      acc++;
    end
    if (!keep || acc != n) begin in_valid = 1'b0; in_last = 1'b0; end
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 1'b0;
    for (int w = 0; w < 3000 && !seen; w++) begin
      @(negedge clk); seen = frame_done;
    end
    chk(nm, seen, 1);
    @(posedge clk); #1;
  endtask

  task automatic normal_frame(input int n, input string nm);
    int acc;
    exp_frame(n, 1'b0);
    send(n, 1'b1, 1'b0, 200, acc);
    chk({nm, " accepted"}, acc, n);
    wait_done({nm, " frame_done"});
    chk({nm, " tx_en cycles"}, last_len, 8 + ((n < MIN_LEN) ? MIN_LEN : n) + 4);
    chk({nm, " done gap"}, done_gap, IFG_LEN);
    chk({nm, " drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, er0;
    logic [31:0] r;
    reset_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    #1 chk("reset outputs async", outs(), 0);
    repeat (3) @(posedge clk);
    #1 chk("reset outputs held", outs(), 0);
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("idle after reset", outs(), 0);

    // Single byte: heavy padding
    pay = '{8'hAB};
    normal_frame(1, "1B");

    // Exactly MIN_LEN: no padding, residue over data+FCS
    pay.delete(); for (int i = 0; i < 60; i++) pay.push_back(8'(i));
    normal_frame(60, "60B");
    r = 32'hFFFF_FFFF;
    for (int i = 8; i < last_cap.size(); i++) r = ref_crc(r, last_cap[i]);
    chk("60B residue", bitrev32(r), 32'hC704_DD7B);

    pay.delete(); for (int i = 0; i < 59; i++) pay.push_back(8'(8'hC3 ^ i));
    normal_frame(59, "59B");
    pay.delete(); for (int i = 0; i < 64; i++) pay.push_back(8'(255 - i));
    normal_frame(64, "64B");

    // Underrun after 10 bytes
    pay.delete(); for (int i = 0; i < 10; i++) pay.push_back(8'(8'hA0 + i));
    exp_frame(10, 1'b1);
    er0 = er_cnt;
    send(10, 1'b0, 1'b0, 200, acc);
    wait_done("underrun frame_done");
    chk("underrun tx_er pulses", er_cnt - er0, 1);
    chk("underrun tx_en cycles", last_len, 19);
    chk("underrun done gap", done_gap, IFG_LEN);
    chk("underrun drained", exp_q.size(), 0);
    pay.delete(); for (int i = 0; i < 20; i++) pay.push_back(8'(3 * i + 1));
    normal_frame(20, "post-underrun");

    // Overlength: 1520 offered, cap at MAX_LEN
    pay.delete(); for (int i = 0; i < 1520; i++) pay.push_back(8'(i));
    exp_frame(MAX_LEN, 1'b1);
    er0 = er_cnt;
    send(1520, 1'b0, 1'b0, 12, acc);
    chk("overlength accepted", acc, MAX_LEN);
    wait_done("overlength frame_done");
    chk("overlength tx_er pulses", er_cnt - er0, 1);
    chk("overlength tx_en cycles", last_len, 8 + MAX_LEN + 1);
    chk("overlength drained", exp_q.size(), 0);

    // Back-to-back with in_valid held through FCS/IFG
    pay.delete(); for (int i = 0; i < 60; i++) pay.push_back(8'(8'h40 + i));
    exp_frame(60, 1'b0);
    send(60, 1'b1, 1'b1, 200, acc);
    chk("b2b first accepted", acc, 60);
    pay.delete(); for (int i = 0; i < 60; i++) pay.push_back(8'(8'h90 ^ i));
    exp_frame(60, 1'b0);
    send(60, 1'b1, 1'b0, 200, acc);
    chk("b2b second accepted", acc, 60);
    wait_done("b2b frame_done");
    chk("b2b ifg cycles", gap_low - gap_idle, IFG_LEN);
    chk("b2b idle cycles", gap_idle, 1);
    chk("b2b tx_en cycles", last_len, 72);
    chk("b2b drained", exp_q.size(), 0);

    // Reset during FCS byte 2
    pay.delete(); for (int i = 0; i < 60; i++) pay.push_back(8'(8'h10 + i));
    exp_frame(60, 1'b0);
    send(60, 1'b1, 1'b0, 200, acc);
    @(posedge clk);
    @(posedge clk); #2;
    chk("bytes before reset", en_cnt, 70);
    reset_n = 1'b0;
    #1 chk("mid-frame reset outputs", outs(), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("after reset release", outs(), 0);
    pay = '{8'h5A};
    normal_frame(1, "post-reset");

    repeat (5) @(posedge clk);
    chk("final queue empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
